// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with optional LF->CRLF expansion feeding uart_tx
// Ports: wr_en/wr_data push side (wr_full, level, sticky overflow cleared by ovf_clr);
//        tx_req/tx_data held until a tx_ready pulse from uart_tx.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter bit CRLF_EXPAND = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     tx_req,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, HOLD, CR_PEND} state_e;
  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    data_q, data_d, head;
  logic          ovf_q, ovf_d, push, pop, lf;
  assign wr_full  = count_q == (AW+1)'(DEPTH);
  assign push     = wr_en && !wr_full;
  assign head     = mem_q[rd_ptr_q];
  assign lf       = CRLF_EXPAND && head == 8'h0A;
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // a rejected push wins over a simultaneous clear
  assign ovf_d    = (wr_en && wr_full) || (ovf_q && !ovf_clr);
  assign level    = count_q;
  assign overflow = ovf_q;
  assign tx_req   = state_q != EMPTY;
  assign tx_data  = data_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (state_q == EMPTY || (state_q == HOLD && tx_ready)) begin
      if (count_q != '0) begin
        pop     = 1'b1;
        data_d  = lf ? 8'h0D : head;
        state_d = lf ? CR_PEND : HOLD;
      end else begin
        state_d = EMPTY;
      end
    end else if (state_q == CR_PEND && tx_ready) begin
      data_d  = 8'h0A;
      state_d = HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      data_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a modelled uart_tx consumer
module tb_uart_tx_fifo;
  localparam int BAUD = 4;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0, ovf_clr = 1'b0, rdy_auto = 1'b0, rdy_man = 1'b0, tx_ready;
  logic [7:0] wr_data = 8'h00;
  logic       wr_full, overflow, tx_req;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       wr_en0 = 1'b0, tx_ready0 = 1'b0, wr_full0, overflow0, tx_req0;
  logic [7:0] wr_data0 = 8'h00, tx_data0;
  logic [4:0] level0;
  logic       auto_rx = 1'b0, cont_chk = 1'b0;
  int         checks = 0, errors = 0;
  logic [7:0] sb[$];
  assign tx_ready = rdy_auto | rdy_man;
  always #5 clk = ~clk;
  uart_tx_fifo #(.DEPTH(16), .CRLF_EXPAND(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .tx_req(tx_req),
    .tx_data(tx_data), .tx_ready(tx_ready));
  uart_tx_fifo #(.DEPTH(16), .CRLF_EXPAND(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en0), .wr_data(wr_data0), .wr_full(wr_full0),
    .level(level0), .overflow(overflow0), .ovf_clr(1'b0), .tx_req(tx_req0),
    .tx_data(tx_data0), .tx_ready(tx_ready0));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // uart_tx model: takes the byte on tx_req, pulses tx_ready, then stays busy
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (auto_rx && tx_req) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL line_byte: got %0h with nothing expected", tx_data);
        end else begin
          e = sb.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL line_byte: got %0h expected %0h", tx_data, e);
          end
        end
        rdy_auto = 1'b1;
        @(negedge clk);
        rdy_auto = 1'b0;
        if (cont_chk && sb.size() > 0) chk("no_gap", tx_req, 1);
        repeat (BAUD - 2) @(negedge clk);
      end
    end
  end
  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((sb.size() != 0 || tx_req) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_idle", tx_req, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req", tx_req, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_level", level, 0);
    reset_n = 1'b1;
    @(negedge clk);
    // 1: single byte latency
    push(8'h41);
    chk("t1_level", level, 1);
    chk("t1_req_early", tx_req, 0);
    @(negedge clk);
    chk("t1_req", tx_req, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_level_pop", level, 0);
    rdy_man = 1'b1;
    @(negedge clk);
    rdy_man = 1'b0;
    chk("t1_req_done", tx_req, 0);
    chk("t1_level_done", level, 0);
    // 2: ABC back-to-back
    auto_rx = 1'b1;
    cont_chk = 1'b1;
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
    push(8'h41); push(8'h42); push(8'h43);
    drain(200);
    chk("t2_ovf", overflow, 0);
    // 3: LF expansion, one entry consumed
    sb.push_back(8'h0D); sb.push_back(8'h0A); sb.push_back(8'h42);
    push(8'h0A); push(8'h42);
    drain(200);
    cont_chk = 1'b0;
    auto_rx = 1'b0;
    // 3b: no expansion
    wr_en0 = 1'b1; wr_data0 = 8'h0A;
    @(negedge clk);
    wr_en0 = 1'b0;
    @(negedge clk);
    chk("t3_raw_req", tx_req0, 1);
    chk("t3_raw_data", tx_data0, 8'h0A);
    tx_ready0 = 1'b1;
    @(negedge clk);
    tx_ready0 = 1'b0;
    chk("t3_raw_single", tx_req0, 0);
    // 4: overfill with tx_ready held low
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("t4_data", tx_data, 8'h50);
    chk("t4_level", level, 16);
    chk("t4_full", wr_full, 1);
    chk("t4_ovf", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    // 5: push and pop together while full
    wr_en = 1'b1; wr_data = 8'hEE; rdy_man = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rdy_man = 1'b0;
    chk("t5_level", level, 15);
    chk("t5_ovf", overflow, 1);
    chk("t5_full", wr_full, 0);
    chk("t5_data", tx_data, 8'h51);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    for (int i = 1; i <= 16; i++) sb.push_back(8'h50 + 8'(i));
    auto_rx = 1'b1;
    n = 0;
    while (level > 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_level_low", level <= 4, 1);
    for (int i = 0; i < 11; i++) begin
      sb.push_back(8'h70 + 8'(i));
      push(8'h70 + 8'(i));
    end
    drain(500);
    chk("t5_ovf_end", overflow, 0);
    auto_rx = 1'b0;
    // 6: async reset while in CR_PEND with 5 queued
    push(8'h0A);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    chk("t6_req", tx_req, 1);
    chk("t6_data", tx_data, 8'h0D);
    chk("t6_level", level, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_req", tx_req, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_data", tx_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t6_quiet", tx_req, 0);
    end
    chk("t6_level_end", level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
